// File: rtl/bht_pkg.sv
// Shared definitions for the branch history table: 2-bit counter
// encodings, the reset value and the pure helper functions used by the
// table and its lookup path.
package bht_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bht_ctr_e;

   // Every entry comes out of reset weakly not-taken.
   localparam logic [1:0] CTR_RST = WNT;

   // Registered prediction handed to fetch.
   typedef struct packed {
      logic       valid;
      logic       taken;
      logic [1:0] state;
   } bht_pred_t;

   // Counter transition on a resolved branch. Not a textbook 2-bit
   // counter: a taken outcome from WNT jumps straight to ST.
   function automatic logic [1:0] next_ctr(input logic [1:0] state, input logic taken);
      logic [1:0] nxt;
      nxt = state;
      case (state)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? ST  : SNT;
         WT:      nxt = taken ? ST  : SNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = CTR_RST;
      endcase
      return nxt;
   endfunction

   // Word-aligned PC bits [bits+1:2] form the table index; callers
   // truncate the result to their own index width.
   function automatic logic [31:0] bht_idx(input logic [63:0] pc, input int unsigned bits);
      logic [63:0] mask;
      mask = (64'd1 << bits) - 64'd1;
      return 32'((pc >> 2) & mask);
   endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones,
// synchronous clear has priority.
module bht_sat_counter
   import bht_pkg::*;
#(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 clear,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   // Increment unless already saturated; never wrap.
   always_ff @(posedge clock) begin
      if (clear)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/bht_pred_table.sv
// Branch history table: 2^IDX_BITS two-bit counters indexed by PC,
// one registered lookup and one update per cycle, plus saturating
// update / mispredict statistics.
// Optional build macro: BHT_BYPASS_EN -- a same-cycle lookup to the
// entry being updated returns the freshly computed next state.
module bht_pred_table
   import bht_pkg::*;
#(
   parameter int PC_WIDTH  = 32,
   parameter int IDX_BITS  = 6,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 lkup_valid,
   input  logic [PC_WIDTH-1:0]  lkup_pc,
   output logic                 pred_valid,
   output logic                 pred_taken,
   output logic [1:0]           pred_state,
   input  logic                 upd_valid,
   input  logic [PC_WIDTH-1:0]  upd_pc,
   input  logic                 upd_taken,
   output logic [CNT_WIDTH-1:0] upd_count,
   output logic [CNT_WIDTH-1:0] mispred_cnt
);

   localparam int ENTRIES = 1 << IDX_BITS;

   logic [ENTRIES-1:0][1:0] tbl;
   logic [IDX_BITS-1:0]     lkup_idx;
   logic [IDX_BITS-1:0]     upd_idx;
   logic [1:0]              upd_old;
   logic [1:0]              upd_next;
   logic [1:0]              rd_val;
   logic                    upd_apply;
   logic                    mis_apply;
   bht_pred_t               pred_q;

   assign lkup_idx = IDX_BITS'(bht_idx(64'(lkup_pc), IDX_BITS));
   assign upd_idx  = IDX_BITS'(bht_idx(64'(upd_pc), IDX_BITS));
   assign upd_old  = tbl[upd_idx];
   assign upd_next = next_ctr(upd_old, upd_taken);

   // Read path: stored value, or the in-flight update when bypassing.
`ifdef BHT_BYPASS_EN
   assign rd_val = (upd_valid && (upd_idx == lkup_idx)) ? upd_next : tbl[lkup_idx];
`else
   assign rd_val = tbl[lkup_idx];
`endif

   // Table: reset every entry to weakly not-taken, else apply the update.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++)
            tbl[i] <= CTR_RST;
      end else if (upd_valid) begin
         tbl[upd_idx] <= upd_next;
      end
   end

   // Lookup register: valid pulses with the request, data holds otherwise.
   always_ff @(posedge clock) begin
      if (reset) begin
         pred_q <= '0;
      end else if (lkup_valid) begin
         pred_q.valid <= 1'b1;
         pred_q.taken <= rd_val[1];
         pred_q.state <= rd_val;
      end else begin
         pred_q.valid <= 1'b0;
      end
   end

   assign pred_valid = pred_q.valid;
   assign pred_taken = pred_q.taken;
   assign pred_state = pred_q.state;

   // Statistics qualifiers: a mispredict compares the pre-update MSB.
   assign upd_apply = upd_valid;
   assign mis_apply = upd_valid && (upd_old[1] != upd_taken);

   bht_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_upd_cnt (
      .clock (clock),
      .clear (reset),
      .inc   (upd_apply),
      .count (upd_count)
   );

   bht_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_mis_cnt (
      .clock (clock),
      .clear (reset),
      .inc   (mis_apply),
      .count (mispred_cnt)
   );

endmodule

// File: tb/tb_bht_pred_table.sv
// Self-checking bench for bht_pred_table (IDX_BITS=6, CNT_WIDTH=4).
// Expected outputs come from a behavioural table model, queued at drive
// time and compared one cycle later. Build with or without BHT_BYPASS_EN.
module tb_bht_pred_table;

   localparam int PW = 32;
   localparam int IB = 6;
   localparam int CW = 4;
`ifdef BHT_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset;
   logic          lkup_valid;
   logic [PW-1:0] lkup_pc;
   logic          pred_valid;
   logic          pred_taken;
   logic [1:0]    pred_state;
   logic          upd_valid;
   logic [PW-1:0] upd_pc;
   logic          upd_taken;
   logic [CW-1:0] upd_count;
   logic [CW-1:0] mispred_cnt;

   always #5 clock = ~clock;

   bht_pred_table #(.PC_WIDTH(PW), .IDX_BITS(IB), .CNT_WIDTH(CW)) dut (
      .clock       (clock),
      .reset       (reset),
      .lkup_valid  (lkup_valid),
      .lkup_pc     (lkup_pc),
      .pred_valid  (pred_valid),
      .pred_taken  (pred_taken),
      .pred_state  (pred_state),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_taken   (upd_taken),
      .upd_count   (upd_count),
      .mispred_cnt (mispred_cnt)
   );

   typedef struct {
      string         tag;
      logic          v;
      logic          t;
      logic [1:0]    s;
      logic [CW-1:0] uc;
      logic [CW-1:0] mc;
   } exp_t;

   exp_t          sb[$];
   logic [1:0]    mtbl [64];
   logic [1:0]    m_pst;
   logic          m_pt;
   logic [CW-1:0] m_uc;
   logic [CW-1:0] m_mc;
   int            checks = 0;
   int            errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Transition table written out from the counter description.
   function automatic logic [1:0] ref_next(input logic [1:0] s, input logic t);
      case ({s, t})
         3'b00_1: return 2'b01;
         3'b00_0: return 2'b00;
         3'b01_1: return 2'b11;
         3'b01_0: return 2'b00;
         3'b10_1: return 2'b11;
         3'b10_0: return 2'b00;
         3'b11_1: return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   // Drive one cycle, push the model's expectation, compare after the edge.
   task automatic cyc(input string tag, input logic r, input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic ut);
      exp_t       e;
      int         li, ui;
      logic [1:0] nxt;
      reset = r; lkup_valid = lv; lkup_pc = lpc;
      upd_valid = uv; upd_pc = upc; upd_taken = ut;
      li = int'((lpc >> 2) % 64);
      ui = int'((upc >> 2) % 64);
      e.tag = tag;
      if (r) begin
         for (int i = 0; i < 64; i++) mtbl[i] = 2'b01;
         m_pst = 2'b00; m_pt = 1'b0; m_uc = '0; m_mc = '0;
         e.v = 1'b0;
      end else begin
         nxt = ref_next(mtbl[ui], ut);
         e.v = lv;
         if (lv) begin
            m_pst = (BYP && uv && (ui == li)) ? nxt : mtbl[li];
            m_pt  = m_pst[1];
         end
         if (uv) begin
            if (m_uc != '1) m_uc++;
            if ((mtbl[ui][1] != ut) && (m_mc != '1)) m_mc++;
            mtbl[ui] = nxt;
         end
      end
      e.t = m_pt; e.s = m_pst; e.uc = m_uc; e.mc = m_mc;
      sb.push_back(e);
      @(posedge clock);
      #1;
      e = sb.pop_front();
      chk({e.tag, ".pred_valid"},  32'(pred_valid),  32'(e.v));
      chk({e.tag, ".pred_taken"},  32'(pred_taken),  32'(e.t));
      chk({e.tag, ".pred_state"},  32'(pred_state),  32'(e.s));
      chk({e.tag, ".upd_count"},   32'(upd_count),   32'(e.uc));
      chk({e.tag, ".mispred_cnt"}, 32'(mispred_cnt), 32'(e.mc));
   endtask

   initial begin
      logic t;
      reset = 1'b1; lkup_valid = 1'b0; lkup_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;

      cyc("rst0", 1, 1, 32'h40, 1, 32'h40, 1);
      cyc("rst1", 1, 0, 0, 0, 0, 0);
      chk("reset_state", 32'(pred_state), 32'h0);

      // First lookup after reset sees the weakly-not-taken entry.
      cyc("lk40", 0, 1, 32'h40, 0, 0, 0);
      chk("first_lookup", 32'(pred_state), 32'h1);

      // Training sequence T,T,N,N on pc 0x40.
      cyc("u40a", 0, 0, 0, 1, 32'h40, 1);
      cyc("l40a", 0, 1, 32'h40, 0, 0, 0);
      chk("train_a", 32'(pred_state), 32'h3);
      cyc("u40b", 0, 0, 0, 1, 32'h40, 1);
      cyc("l40b", 0, 1, 32'h40, 0, 0, 0);
      cyc("u40c", 0, 0, 0, 1, 32'h40, 0);
      cyc("l40c", 0, 1, 32'h40, 0, 0, 0);
      chk("train_c", 32'(pred_state), 32'h2);
      cyc("u40d", 0, 0, 0, 1, 32'h40, 0);
      cyc("l40d", 0, 1, 32'h40, 0, 0, 0);
      chk("train_d", 32'(pred_state), 32'h0);
      chk("train_mis", 32'(mispred_cnt), 32'd3);
      chk("train_upd", 32'(upd_count), 32'd4);
      cyc("idle", 0, 0, 32'h80, 0, 0, 0);

      // Same-cycle lookup and update on one entry.
      cyc("same80", 0, 1, 32'h80, 1, 32'h80, 1);
      chk("same_cycle", 32'(pred_state), BYP ? 32'h3 : 32'h1);
      cyc("next80", 0, 1, 32'h80, 0, 0, 0);
      chk("after_same", 32'(pred_state), 32'h3);

      // Aliasing: 0x100 and 0x000 share index 0; 0x104 does not.
      cyc("u100", 0, 0, 0, 1, 32'h100, 1);
      cyc("l000", 0, 1, 32'h000, 0, 0, 0);
      chk("alias_hit", 32'(pred_state), 32'h3);
      cyc("l104", 0, 1, 32'h104, 1, 32'h80, 0);
      chk("alias_miss", 32'(pred_state), 32'h1);

      // T,N,N,T from WNT mispredicts every time; drive into saturation.
      for (int i = 0; i < 20; i++) begin
         t = ((i % 4) == 0) || ((i % 4) == 3);
         cyc("sat", 0, (i % 3) == 0, 32'h8, 1, 32'h8, t);
      end
      chk("sat_upd", 32'(upd_count), 32'd15);
      chk("sat_mis", 32'(mispred_cnt), 32'd15);
      cyc("sat_hold", 0, 0, 0, 1, 32'h8, 1);
      chk("sat_upd_hold", 32'(upd_count), 32'd15);

      // Retrain 0x40 to ST, then reset mid-stream with traffic present.
      cyc("r40a", 0, 0, 0, 1, 32'h40, 1);
      cyc("r40b", 0, 0, 0, 1, 32'h40, 1);
      cyc("r40c", 0, 1, 32'h40, 0, 0, 0);
      chk("pre_reset", 32'(pred_state), 32'h3);
      cyc("midrst", 1, 1, 32'h40, 1, 32'h40, 1);
      chk("midrst_valid", 32'(pred_valid), 32'h0);
      chk("midrst_cnt", 32'(upd_count), 32'h0);
      cyc("post_rst", 0, 1, 32'h40, 0, 0, 0);
      chk("post_rst_state", 32'(pred_state), 32'h1);

      // Random traffic over a small, aliasing PC range.
      for (int i = 0; i < 80; i++) begin
         cyc("rand", ($urandom_range(0, 39) == 0),
             1'($urandom_range(0, 1)),
             32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2)),
             1'($urandom_range(0, 1)),
             32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2)),
             1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
